// File: rtl/mem_ctrl_mc_if.sv
// Requester + host bundle for mem_ctrl_mc. The controller uses master and the environment uses slave.
// Parameters must match the controller instance.
interface mem_ctrl_mc_if #(
   parameter int WORD_SIZE     = 32,
   parameter int CL_SIZE_WIDTH = 512,
   parameter int ADDR_BITCOUNT = 64,
   parameter int NUM_CH        = 2
);
   logic                            host_init;
   logic [ADDR_BITCOUNT-1:0]        address_offset;
   logic [2*NUM_CH-1:0]             req_op;
   logic [ADDR_BITCOUNT*NUM_CH-1:0] req_addr;
   logic [WORD_SIZE*NUM_CH-1:0]     wr_data;
   logic [NUM_CH-1:0]               wr_valid;
   logic                            ready;
   logic [NUM_CH-1:0]               grant;
   logic [WORD_SIZE-1:0]            rd_data;
   logic                            rd_valid;
   logic                            wr_accept;
   logic                            tx_done;
   logic [ADDR_BITCOUNT-1:0]        host_addr;
   logic                            host_re;
   logic                            host_we;
   logic                            host_rd_ready;
   logic                            host_wr_ready;
   logic [CL_SIZE_WIDTH-1:0]        host_data_in;
   logic [CL_SIZE_WIDTH-1:0]        host_data_out;

   modport master (
      input  host_init, address_offset, req_op, req_addr, wr_data, wr_valid,
             host_rd_ready, host_wr_ready, host_data_in,
      output ready, grant, rd_data, rd_valid, wr_accept, tx_done,
             host_addr, host_re, host_we, host_data_out
   );

   modport slave (
      output host_init, address_offset, req_op, req_addr, wr_data, wr_valid,
             host_rd_ready, host_wr_ready, host_data_in,
      input  ready, grant, rd_data, rd_valid, wr_accept, tx_done,
             host_addr, host_re, host_we, host_data_out
   );
endinterface

// File: rtl/mem_ctrl_mc.sv
// Round-robin multi-channel word<->line memory controller. Read: grant + host wait + FILL_COUNT drain;
// write: gather FILL_COUNT words (stalls on wr_valid gaps), then one host write held until host_wr_ready.
module mem_ctrl_mc #(
   parameter int WORD_SIZE     = 32,
   parameter int CL_SIZE_WIDTH = 512,
   parameter int ADDR_BITCOUNT = 64,
   parameter int NUM_CH        = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_ctrl_mc_if.master bus
);
   localparam int FILL_COUNT = CL_SIZE_WIDTH / WORD_SIZE;
   localparam int CNT_W      = $clog2(FILL_COUNT);
   localparam int OFF_BITS   = $clog2(CL_SIZE_WIDTH / 8);
   localparam int GW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_COUNT - 1);
   localparam logic [ADDR_BITCOUNT-1:0] LINE_MASK =
      {{(ADDR_BITCOUNT-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

   typedef enum logic [2:0] {STARTUP, IDLE, RD_HOST, RD_DRAIN, WR_FILL, WR_HOST} state_t;

   state_t                     state_q, state_d;
   logic [NUM_CH-1:0]          grant_q, grant_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [CL_SIZE_WIDTH-1:0]   line_buf_q, line_buf_d;
   logic [ADDR_BITCOUNT-1:0]   addr_q, addr_d;
   logic [GW-1:0]              last_grant_q, last_grant_d;

   logic [NUM_CH-1:0]          req_vld;
   logic                       win_found;
   logic [GW-1:0]              win;
   logic                       win_wr;
   logic [ADDR_BITCOUNT-1:0]   win_addr;
   logic                       wr_vld_sel;
   logic [WORD_SIZE-1:0]       wr_dat_sel;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         req_vld[c] = (bus.req_op[2*c +: 2] == 2'b01) || (bus.req_op[2*c +: 2] == 2'b11);
      end
   end

   // Search upward from the channel after the last winner, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win       = last_grant_q;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = (int'(last_grant_q) + i) % NUM_CH;
         if (!win_found && req_vld[idx]) begin
            win_found = 1'b1;
            win       = GW'(idx);
         end
      end
   end

   assign win_wr     = bus.req_op[2*int'(win) + 1];
   assign win_addr   = bus.req_addr[int'(win)*ADDR_BITCOUNT +: ADDR_BITCOUNT];
   assign wr_vld_sel = bus.wr_valid[last_grant_q];
   assign wr_dat_sel = bus.wr_data[int'(last_grant_q)*WORD_SIZE +: WORD_SIZE];

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      line_buf_d   = line_buf_q;
      addr_d       = addr_q;
      last_grant_d = last_grant_q;
      case (state_q)
         STARTUP: if (bus.host_init) state_d = IDLE;
         IDLE: begin
            if (win_found) begin
               grant_d      = '0;
               grant_d[win] = 1'b1;
               last_grant_d = win;
               addr_d       = (win_addr + bus.address_offset) & LINE_MASK;
               cnt_d        = '0;
               state_d      = win_wr ? WR_FILL : RD_HOST;
            end
         end
         RD_HOST: begin
            if (bus.host_rd_ready) begin
               line_buf_d = bus.host_data_in;
               cnt_d      = '0;
               state_d    = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         WR_FILL: begin
            if (wr_vld_sel) begin
               line_buf_d[int'(cnt_q)*WORD_SIZE +: WORD_SIZE] = wr_dat_sel;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) state_d = WR_HOST;
            end
         end
         WR_HOST: begin
            if (bus.host_wr_ready) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = STARTUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= STARTUP;
         grant_q      <= '0;
         cnt_q        <= '0;
         line_buf_q   <= '0;
         addr_q       <= '0;
         last_grant_q <= GW'(NUM_CH - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         line_buf_q   <= line_buf_d;
         addr_q       <= addr_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Only wr_accept and the write-side tx_done see inputs combinationally.
   assign bus.ready         = (state_q != STARTUP);
   assign bus.grant         = grant_q;
   assign bus.rd_valid      = (state_q == RD_DRAIN);
   assign bus.rd_data       = line_buf_q[int'(cnt_q)*WORD_SIZE +: WORD_SIZE];
   assign bus.wr_accept     = (state_q == WR_FILL) && wr_vld_sel;
   assign bus.tx_done       = ((state_q == RD_DRAIN) && (cnt_q == CNT_LAST)) ||
                              ((state_q == WR_HOST) && bus.host_wr_ready);
   assign bus.host_re       = (state_q == RD_HOST);
   assign bus.host_we       = (state_q == WR_HOST);
   assign bus.host_addr     = addr_q;
   assign bus.host_data_out = line_buf_q;
endmodule

// File: doc/mem_ctrl_mc.md
# mem_ctrl_mc

Multi-channel, parametrised memory controller between NUM_CH word-wide requesters (caches/MSHRs) and one cache-line-wide host memory port. It arbitrates requests round-robin, latches the granted channel's opcode and address, and converts between word streams and whole lines. Reads fetch one line from the host and stream it out a word per cycle. Writes gather a line of words from the requester, then issue one host write to the line-aligned, offset-corrected address.

## Interface
- WORD_SIZE, 32, requester word width in bits
- CL_SIZE_WIDTH, 512, host line width in bits; must be a multiple of WORD_SIZE; FILL_COUNT = CL_SIZE_WIDTH/WORD_SIZE must be a power of 2 and at least 2
- ADDR_BITCOUNT, 64, address width
- NUM_CH, 2, number of requester channels, at least 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- host_init  in  1  host link initialised
- address_offset  in  ADDR_BITCOUNT  added to every request address
- req_op  in  2*NUM_CH  per channel: 2'b01 READ, 2'b11 WRITE, others none; channel c is at [2c+1:2c]
- req_addr  in  ADDR_BITCOUNT*NUM_CH  per-channel byte address
- wr_data  in  WORD_SIZE*NUM_CH  per-channel write word
- wr_valid  in  NUM_CH  per-channel write word valid
- ready  out  1  controller is out of STARTUP
- grant  out  NUM_CH  one-hot owner of the current transaction; 0 when IDLE
- rd_data  out  WORD_SIZE  read word, shared by all channels
- rd_valid  out  1  rd_data is valid for the granted channel
- wr_accept  out  1  the granted channel's wr_data is consumed this cycle
- tx_done  out  1  last cycle of the transaction
- host_addr  out  ADDR_BITCOUNT  line-aligned host address
- host_re / host_we  out  1  host read / write request
- host_rd_ready / host_wr_ready  in  1  host read data present / write accepted
- host_data_in  in  CL_SIZE_WIDTH  host read line
- host_data_out  out  CL_SIZE_WIDTH  line buffer

## Operation
- States: STARTUP, IDLE, RD_HOST, RD_DRAIN, WR_FILL, WR_HOST.
- STARTUP: ready=0. All requests are ignored. host_init=1 moves to IDLE; host_init is not sampled after that.
- IDLE: a channel is requesting if its req_op is READ or WRITE.
  - The winner is the first requesting channel searched upward, with wrap, from (last_grant+1) mod NUM_CH. last_grant resets to NUM_CH-1, so channel 0 has first priority.
  - On the winning edge, latch grant, opcode and addr_q = (req_addr + address_offset) mod 2^ADDR_BITCOUNT with the low $clog2(CL_SIZE_WIDTH/8) bits cleared. Update last_grant.
  - Next state is RD_HOST for READ, WR_FILL for WRITE.
- Opcode and address are latched. Later changes to req_op or req_addr do not affect the transaction in flight.
- RD_HOST: host_re=1. On the edge where host_rd_ready=1, line_buf ← host_data_in, cnt←0, go to RD_DRAIN.
- RD_DRAIN: rd_valid=1 and rd_data=line_buf word[cnt] (word i = bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE]). cnt increments every cycle. When cnt=FILL_COUNT-1, tx_done=1 and the next state is IDLE.
- WR_FILL: wr_accept = wr_valid[granted].
  - Each accepted word is written to word[cnt] of line_buf and cnt increments. Gaps in wr_valid stall the fill.
  - Accepting with cnt=FILL_COUNT-1 moves to WR_HOST.
- WR_HOST: host_we=1. When host_wr_ready=1, tx_done=1 combinationally and the next state is IDLE.
- host_addr = addr_q. host_data_out = line_buf.
- cnt is $clog2(FILL_COUNT) bits and wraps to 0 at the end of a drain or fill.
- The requester must drop req_op on the cycle it sees tx_done. Otherwise it re-requests, and is re-granted only if no other channel is requesting.

## Timing
- Reset values: state STARTUP; grant 0; cnt 0; line_buf 0; addr_q 0; last_grant NUM_CH-1. Outputs: ready 0, rd_valid 0, wr_accept 0, tx_done 0, host_re 0, host_we 0, host_addr 0, host_data_out 0, rd_data 0.
- Reset asserted mid-transaction aborts immediately with no host strobe afterwards. The requester must reissue the request.
- A request present at IDLE edge k gives grant and host_re (or wr_accept eligibility) from cycle k+1.
- Read latency is 1 (grant) + host wait + FILL_COUNT drain cycles. tx_done coincides with the last rd_valid.
- Write: the first word can be accepted in the cycle after grant. host_we rises in the cycle after the last accepted word.
- Minimum idle gap between transactions is 1 cycle (the IDLE arbitration cycle).
- Outputs are decoded from registered state. The only combinational input-to-output paths are: wr_accept depends on wr_valid, and tx_done in WR_HOST depends on host_wr_ready.

## Test plan
- Reset, hold host_init=0 for 10 cycles with READ on ch0 -> ready=0, grant=0, host_re=0; host_init=1 -> ready=1 next cycle.
- READ ch0, req_addr=0x1234, address_offset=0x1000, host_data_in word i = 0xA0+i, host_rd_ready 3 cycles late -> host_addr=0x2200. Then 16 rd_valid cycles with rd_data 0xA0..0xAF; tx_done on 0xAF.
- WRITE ch1, wr_data 0x1..0x10 with wr_valid low on every 3rd cycle -> 16 accepts. host_we asserted with host_data_out word i = i+1. tx_done in the host_wr_ready cycle.
- ch0 and ch1 both request READ continuously from reset -> grants alternate ch0, ch1, ch0.
- Change req_op and req_addr of the granted channel mid-fill -> the transaction completes unchanged with the latched address.
- Assert rst_n low during RD_DRAIN at cnt=5 -> all outputs return to reset values asynchronously; STARTUP is re-entered and no host_re occurs until host_init is seen again.
